// File: rtl/wptr_full_mw_pkg.sv
// Shared helpers for the multi-write async FIFO pointer blocks.
//   depth_of(addrsize) : number of FIFO entries for a given address width
//   bin2gray(b)        : reflected binary to Gray conversion (32-bit carrier,
//                        callers cast the result down to their pointer width)
package wptr_full_mw_pkg;

    function automatic int depth_of(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Purely combinational Gray to binary converter of parametrised width.
// Each binary bit is the XOR of all Gray bits at and above its position.
//   gray  in  W  Gray-coded value
//   bin   out W  binary equivalent
module gray2bin_n #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/wptr_full_mw.sv
// Write-side pointer and flag generator for the multi-write async FIFO.
// Accepts up to WRMAX entries per cycle on an all-or-nothing basis, tracks a
// binary/Gray write pointer pair, and produces a registered fill level plus
// full, almost-full and sticky overflow flags.
//   wclk        in  1           write clock
//   wrst        in  1           synchronous active-high reset
//   wcnt        in  CW          entries offered this cycle (0 = idle)
//   wq2_rptr    in  ADDRSIZE+1  read pointer, Gray, already synchronised
//   awfull_thr  in  ADDRSIZE+1  almost-full threshold (quasi-static)
//   wovf_clr    in  1           clears the sticky overflow flag
//   wacc        out CW          entries accepted this cycle (combinational)
//   waddr       out ADDRSIZE    base RAM address for this cycle's writes
//   wptr        out ADDRSIZE+1  registered Gray write pointer
//   wlevel      out ADDRSIZE+1  registered fill level, 0..DEPTH
//   wfull       out 1           level == DEPTH
//   awfull      out 1           level >= awfull_thr
//   wovf        out 1           sticky overflow (request rejected)
module wptr_full_mw
    import wptr_full_mw_pkg::*;
#(
    parameter  int ADDRSIZE = 4,
    parameter  int WRMAX    = 4,
    localparam int CW       = $clog2(WRMAX + 1)
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic [CW-1:0]       wcnt,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   awfull_thr,
    input  logic                wovf_clr,
    output logic [CW-1:0]       wacc,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wfull,
    output logic                awfull,
    output logic                wovf
);

    localparam int P     = ADDRSIZE + 1;
    localparam int DEPTH = depth_of(ADDRSIZE);

    logic [P-1:0] wbin;
    logic [P-1:0] rbin;
    logic [P-1:0] used;
    logic [P-1:0] free;
    logic [P-1:0] wbinnext;
    logic [P-1:0] wgraynext;
    logic [P-1:0] lvlnext;
    logic         ovf_set;

    gray2bin_n #(.W(P)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // Modulo-2**P arithmetic: the extra MSB makes used range 0..DEPTH, so
    // free also stays in 0..DEPTH and fits in P bits.
    always_comb begin
        used      = wbin - rbin;
        free      = P'(DEPTH) - used;
        wacc      = '0;
        if (!wrst && (P'(wcnt) <= free)) begin
            wacc = wcnt;
        end
        wbinnext  = wbin + P'(wacc);
        wgraynext = P'(bin2gray(32'(wbinnext)));
        lvlnext   = wbinnext - rbin;
        ovf_set   = (wcnt != '0) && (wacc == '0);
    end

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wlevel <= '0;
            wfull  <= 1'b0;
            awfull <= 1'b0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wlevel <= lvlnext;
            wfull  <= (lvlnext == P'(DEPTH));
            awfull <= (lvlnext >= awfull_thr);
            // A new rejection outranks a simultaneous clear.
            wovf   <= ovf_set | (wovf & ~wovf_clr);
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            assert (wcnt <= CW'(WRMAX))
                else $error("wptr_full_mw: wcnt %0d exceeds WRMAX %0d", wcnt, WRMAX);
        end
    end

endmodule

// File: tb/tb_wptr_full_mw.sv
module tb_wptr_full_mw;

    localparam int ADDRSIZE = 3;
    localparam int WRMAX    = 4;
    localparam int CW       = $clog2(WRMAX + 1);

    logic                wclk = 1'b0;
    logic                wrst;
    logic [CW-1:0]       wcnt;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   awfull_thr;
    logic                wovf_clr;
    logic [CW-1:0]       wacc;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                wfull;
    logic                awfull;
    logic                wovf;

    int errors = 0;
    int checks = 0;

    wptr_full_mw #(.ADDRSIZE(ADDRSIZE), .WRMAX(WRMAX)) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .wcnt       (wcnt),
        .wq2_rptr   (wq2_rptr),
        .awfull_thr (awfull_thr),
        .wovf_clr   (wovf_clr),
        .wacc       (wacc),
        .waddr      (waddr),
        .wptr       (wptr),
        .wlevel     (wlevel),
        .wfull      (wfull),
        .awfull     (awfull),
        .wovf       (wovf)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input int lvl, input int ptr,
                            input int full, input int afull, input int ovf);
        chk({tag, ".wlevel"}, 32'(wlevel), lvl);
        chk({tag, ".wptr"},   32'(wptr),   ptr);
        chk({tag, ".wfull"},  32'(wfull),  full);
        chk({tag, ".awfull"}, 32'(awfull), afull);
        chk({tag, ".wovf"},   32'(wovf),   ovf);
    endtask

    initial begin
        logic [3:0] b;

        wrst = 1'b1; wcnt = 3'd2; wq2_rptr = '0; awfull_thr = 4'd6; wovf_clr = 1'b0;
        #1;
        chk("rst.wacc_forced", 32'(wacc), 0);
        tick();
        tick();
        chk_regs("rst", 0, 0, 0, 0, 0);

        wrst = 1'b0; wcnt = '0;
        tick();
        chk_regs("idle", 0, 0, 0, 0, 0);
        chk("idle.wacc", 32'(wacc), 0);

        // two bursts of 4 fill the FIFO
        wcnt = 3'd4;
        #1;
        chk("burst1.wacc",  32'(wacc),  4);
        chk("burst1.waddr", 32'(waddr), 0);
        tick();
        chk_regs("burst1", 4, 6, 0, 0, 0);
        chk("burst2.wacc",  32'(wacc),  4);
        chk("burst2.waddr", 32'(waddr), 4);
        tick();
        chk_regs("burst2", 8, 12, 1, 1, 0);

        // full: rejection sets sticky overflow
        wcnt = 3'd1;
        #1;
        chk("full.wacc", 32'(wacc), 0);
        tick();
        chk_regs("full_rej", 8, 12, 1, 1, 1);
        wcnt = '0;
        tick();
        chk("ovf_sticky", 32'(wovf), 1);
        wcnt = 3'd1; wovf_clr = 1'b1;
        #1;
        chk("clr_rej.wacc", 32'(wacc), 0);
        tick();
        chk("ovf_set_wins", 32'(wovf), 1);
        wcnt = '0;
        tick();
        chk("ovf_cleared", 32'(wovf), 0);
        wovf_clr = 1'b0;

        // read side frees 2 entries -> level 6
        wq2_rptr = 4'd3;
        tick();
        chk_regs("lvl6", 6, 12, 0, 1, 0);
        wcnt = 3'd3;
        #1;
        chk("lvl6_3.wacc", 32'(wacc), 0);
        tick();
        chk("lvl6_3.wovf", 32'(wovf), 1);
        wcnt = 3'd2;
        #1;
        chk("lvl6_2.wacc",  32'(wacc),  2);
        chk("lvl6_2.waddr", 32'(waddr), 0);
        tick();
        chk_regs("lvl6_2", 8, 15, 1, 1, 1);
        wcnt = '0; wovf_clr = 1'b1;
        tick();
        wovf_clr = 1'b0;
        chk("ovf_clr2", 32'(wovf), 0);

        // wrap: wbin=10; read pointer at 9 gives level 1
        wq2_rptr = gray4(4'd9);
        tick();
        chk("wrap_pre.wlevel", 32'(wlevel), 1);
        for (int k = 0; k < 20; k++) begin
            b = 4'(10 + k);
            wcnt = 3'd1;
            wq2_rptr = gray4(b);
            #1;
            chk($sformatf("wrap%0d.wacc", k),  32'(wacc),  1);
            chk($sformatf("wrap%0d.waddr", k), 32'(waddr), 32'(b[2:0]));
            tick();
            chk($sformatf("wrap%0d.wptr", k),   32'(wptr),   32'(gray4(b + 4'd1)));
            chk($sformatf("wrap%0d.wlevel", k), 32'(wlevel), 1);
        end

        // wbin=14; read pointer 9 -> level 5, then overflow, then reset
        wcnt = 3'd4; wq2_rptr = gray4(4'd9);
        #1;
        chk("lvl5.wacc", 32'(wacc), 0);
        tick();
        chk("lvl5.wlevel", 32'(wlevel), 5);
        chk("lvl5.wovf",   32'(wovf),   1);
        wrst = 1'b1; wcnt = '0; wq2_rptr = '0;
        tick();
        chk_regs("midrst", 0, 0, 0, 0, 0);
        wrst = 1'b0; wcnt = 3'd1;
        #1;
        chk("postrst.wacc",  32'(wacc),  1);
        chk("postrst.waddr", 32'(waddr), 0);
        tick();
        chk("postrst.wlevel", 32'(wlevel), 1);
        chk("postrst.wptr",   32'(wptr),   1);

        // threshold boundaries
        wcnt = '0; awfull_thr = 4'd0;
        tick();
        chk("thr0.awfull", 32'(awfull), 1);
        awfull_thr = 4'd1;
        tick();
        chk("thr1.awfull", 32'(awfull), 1);
        awfull_thr = 4'd2;
        tick();
        chk("thr2.awfull", 32'(awfull), 0);
        awfull_thr = 4'd9;
        tick();
        chk("thr9.awfull", 32'(awfull), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wptr_full_mw.md
# wptr_full_mw

Write-side pointer and flag generator for the debug async FIFO, generalised to accept up to WRMAX entries per cycle, with a run-time almost-full threshold, a registered fill level and a sticky overflow flag. It sits in the write clock domain. It takes the read pointer already synchronised into that domain (Gray, two flops, produced outside this block) and drives the write address, the Gray write pointer toward the read domain, and the flow-control flags.

## Interface
- ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE entries
- WRMAX, 4, maximum entries offered per cycle; 1 ≤ WRMAX ≤ DEPTH
- CW, derived, $clog2(WRMAX+1), width of wcnt/wacc

- wclk  in  1  write clock; the only clock
- wrst  in  1  reset, synchronous, active-high
- wcnt  in  CW  entries offered this cycle (0 = idle)
- wq2_rptr  in  ADDRSIZE+1  synchronised Gray read pointer
- awfull_thr  in  ADDRSIZE+1  almost-full level threshold, quasi-static
- wovf_clr  in  1  clears wovf
- wacc  out  CW  entries accepted this cycle (combinational)
- waddr  out  ADDRSIZE  base RAM address for this cycle's writes
- wptr  out  ADDRSIZE+1  registered Gray write pointer
- wlevel  out  ADDRSIZE+1  registered fill level, 0..DEPTH
- wfull  out  1  registered, level == DEPTH
- awfull  out  1  registered, level ≥ awfull_thr
- wovf  out  1  sticky overflow

## Operation
- Internal state: wbin (ADDRSIZE+1 binary), wptr, wlevel, wfull, awfull, wovf.
- rbin = gray2bin(wq2_rptr). free = DEPTH − (wbin − rbin), computed modulo 2**(ADDRSIZE+1).
- All-or-nothing acceptance: wacc = (wcnt ≤ free) ? wcnt : 0. Requests are never partially accepted.
- The RAM writes entries at waddr, waddr+1, …, waddr+wacc−1, all modulo DEPTH. waddr = wbin[ADDRSIZE−1:0].
- wbinnext = wbin + wacc. This wraps at 2**(ADDRSIZE+1), and the extra MSB distinguishes full from empty.
- wgraynext = (wbinnext>>1) ^ wbinnext. lvlnext = wbinnext − rbin.
- On each wclk edge: wbin←wbinnext, wptr←wgraynext, wlevel←lvlnext, wfull←(lvlnext==DEPTH), awfull←(lvlnext ≥ awfull_thr).
- wovf is set when wcnt≠0 and wacc==0, and cleared by wovf_clr. If both happen in the same cycle, set wins.
- Levels are pessimistic because rbin lags the true read pointer by the synchroniser delay. The block never overstates free space.
- Values are unsigned. awfull_thr > DEPTH means awfull is never asserted. awfull_thr = 0 means awfull = 1 from the first cycle after reset.

## Timing
- While wrst is high at a wclk edge: wbin, wptr, wlevel = 0; wfull, awfull, wovf = 0. No acceptance occurs in that cycle, and wacc is forced to 0.
- Reset mid-burst discards pointer state. The read side must be reset in the same window, which is a system requirement.
- wacc is combinational from wcnt, wbin and wq2_rptr in the same cycle. There is no combinational path from wcnt to any registered output other than through state.
- Flags and level lag acceptance by one cycle. A write accepted in cycle N is reflected in wlevel/wfull/awfull/wptr in cycle N+1.
- A read-pointer advance seen in cycle N releases space for acceptance in cycle N, and the flags update in N+1.
- Pointer wrap: wbin rolls from 2**(ADDRSIZE+1)−1 to 0 with no bubble. The level arithmetic stays correct across the wrap.
- wcnt > WRMAX is illegal and is caught by an assertion in simulation only.

## Structure
- Package wptr_full_mw_pkg holds the DEPTH derivation helper and a bin2gray function.
- Sub-module gray2bin_n (parametrised width, purely combinational XOR-prefix) converts wq2_rptr. It is reused by the future rptr_empty_mw.
- All state lives in a single sequential process.

## Test plan
All scenarios use ADDRSIZE=3 (DEPTH=8), WRMAX=4, awfull_thr=6, and rptr held at 0 unless stated.
- Reset, then hold wcnt=0 → wacc=0, wlevel=0, wfull=0, awfull=0, wptr=0, wovf=0.
- wcnt=4 for two cycles → wacc=4 both cycles; wlevel 4 then 8; awfull=1 and wfull=1 on the second flag update; waddr 0 then 4.
- Full (level 8), wcnt=1 → wacc=0 and wovf=1 the next cycle; wovf stays 1 until wovf_clr, and stays 1 if wovf_clr coincides with another rejected request.
- Level 6, wcnt=3 → wacc=0 (all-or-nothing) and wovf set; wcnt=2 → wacc=2, wfull=1.
- Wrap: advance wq2_rptr (Gray) in step with 20 single writes → wptr follows the Gray sequence through 15→0 with no glitch; wlevel is constant at 1.
- Assert wrst with level 5 → next cycle all outputs are 0; the first wcnt=1 afterwards gives waddr=0 and wacc=1.
